// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with load/start/pause control, terminal-count pulse and DONE/RUN levels.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from the last preset at terminal count instead of stopping.
module bcd_countdown_timer #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] preset_i,
  input  logic                start_i,
  input  logic                pause_i,
  output logic [4*DIGITS-1:0] q_o,
  output logic                tc_o,
  output logic                done_o,
  output logic                busy_o
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q;
  logic [W-1:0]   q_q;
  logic           tc_q;
  logic           busy_q;
  logic           done_q;

  logic [W-1:0]   clamp_d;
  logic [W-1:0]   dec_d;
  logic           is_zero;
  logic           is_one;
  logic           start_ok;

  // Out-of-range preset digits saturate to 9 so q always holds legal BCD.
  always_comb begin
    clamp_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      clamp_d[4*i +: 4] = (preset_i[4*i +: 4] > 4'd9) ? 4'd9 : preset_i[4*i +: 4];
    end
  end

  always_comb begin : bcd_dec
    logic borrow;
    dec_d  = q_q;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          dec_d[4*i +: 4] = 4'd9;
        end else begin
          dec_d[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  assign is_zero = (q_q == '0);
  assign is_one  = (q_q == W'(1));

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [W-1:0] shadow_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      shadow_q <= '0;
    end else if (load_i) begin
      shadow_q <= clamp_d;
    end
  end

  // A zero period would never produce a tick-to-terminal event, so refuse to run.
  assign start_ok = !is_zero && (shadow_q != '0);
`else
  assign start_ok = !is_zero;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      q_q     <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load_i) begin
        q_q <= clamp_d;
        // Load while running restarts the count; from any other state it parks in IDLE.
        if (state_q != RUN) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i && start_ok) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
          RUN: begin
            if (pause_i) begin
              state_q <= PAUSE;
              busy_q  <= 1'b0;
            end else if (en_i) begin
              if (is_one) begin
                tc_q <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                q_q  <= shadow_q;
`else
                q_q     <= '0;
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
`endif
              end else if (!is_zero) begin
                q_q <= dec_d;
              end
            end
          end
          PAUSE: begin
            if (start_i) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
          DONE: begin
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign q_o    = q_q;
  assign tc_o   = tc_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer: directed vector table, hand-written corner sequences, random run against an integer model.
module tb_bcd_countdown_timer;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        en_i = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] preset_i = '0;
  logic        start_i = 1'b0;
  logic        pause_i = 1'b0;
  logic [15:0] q_o;
  logic        tc_o;
  logic        done_o;
  logic        busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .clr      (clr),
    .en_i     (en_i),
    .load_i   (load_i),
    .preset_i (preset_i),
    .start_i  (start_i),
    .pause_i  (pause_i),
    .q_o      (q_o),
    .tc_o     (tc_o),
    .done_o   (done_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ld;
    logic [15:0] pre;
    logic        st;
    logic        pa;
    logic        en;
    logic [15:0] eq;
    logic        ebusy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ld, logic [15:0] pre, logic st, logic pa, logic en,
                              logic [15:0] eq, logic ebusy);
    vec_t v;
    v.ld = ld; v.pre = pre; v.st = st; v.pa = pa; v.en = en; v.eq = eq; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic l, input logic [15:0] p, input logic s, input logic pa, input logic e);
    load_i = l; preset_i = p; start_i = s; pause_i = pa; en_i = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    load_i = 0; preset_i = '0; start_i = 0; pause_i = 0; en_i = 0;
    @(posedge clk);
    #1;
    chk("reset_q", q_o, 0);
    chk("reset_tc", tc_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    @(posedge clk);
    #1;
    clr = 1'b1;
  endtask

  // Reference model: the count is a plain integer; BCD only appears at the comparison.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_st, m_val, m_sh;
  bit m_tc;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  function automatic int preset_to_int(logic [15:0] p);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      int d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [15:0] int_to_bcd(int v);
    logic [15:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_step(input logic l, input logic [15:0] p, input logic s, input logic pa, input logic e);
    m_tc = 1'b0;
    if (l) begin
      m_val = preset_to_int(p);
      m_sh  = m_val;
      if (m_st != M_RUN) m_st = M_IDLE;
    end else if (m_st == M_IDLE) begin
      if (s && m_val != 0 && (!RELOAD || m_sh != 0)) m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (pa) m_st = M_PAUSE;
      else if (e && m_val == 1) begin
        m_tc = 1'b1;
        if (RELOAD) m_val = m_sh;
        else begin m_val = 0; m_st = M_DONE; end
      end else if (e && m_val > 1) m_val = m_val - 1;
    end else if (m_st == M_PAUSE) begin
      if (s) m_st = M_RUN;
    end
  endtask

  initial begin
    logic [15:0] exp_q6 [7];
    logic        exp_tc6 [7];
    logic [15:0] pre;
    logic        l, s, pa, e;

    // ---------------- table-driven vectors ----------------
    tbl.push_back(mk(1, 16'h1A0F, 0, 0, 0, 16'h1909, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 16'h0101, 0, 0, 0, 16'h0101, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0101, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0100, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0099, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0098, 1));
    tbl.push_back(mk(1, 16'h0050, 0, 0, 0, 16'h0050, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 1, 16'h0050, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0050, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0050, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0050, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0050, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0049, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h0049, 0));
    tbl.push_back(mk(1, 16'h0012, 1, 0, 0, 16'h0012, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0012, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h0012, 1));
    tbl.push_back(mk(1, 16'h9999, 0, 1, 0, 16'h9999, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h9998, 1));

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].pre, tbl[i].st, tbl[i].pa, tbl[i].en);
      chk($sformatf("tbl%0d_q", i), q_o, tbl[i].eq);
      chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].ebusy);
      chk($sformatf("tbl%0d_tc", i), tc_o, 0);
      chk($sformatf("tbl%0d_done", i), done_o, 0);
    end

    // ---------------- async reset mid-RUN, no clock edge ----------------
    do_reset();
    step(1, 16'h0123, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    step(0, 16'h0000, 0, 0, 1);
    chk("pre_arst_q", q_o, 16'h0121);
    chk("pre_arst_busy", busy_o, 1);
    #2 clr = 1'b0;
    #1;
    chk("arst_q", q_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_tc", tc_o, 0);
    @(posedge clk);
    #1 clr = 1'b1;
    step(0, 16'h0000, 0, 0, 0);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // ---------------- terminal count then DONE ----------------
    step(1, 16'h0002, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk("tc3_q1", q_o, 16'h0001);
    chk("tc3_tc1", tc_o, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk("tc3_q0", q_o, 16'h0000);
    chk("tc3_tc", tc_o, 1);
    chk("tc3_done", done_o, 1);
    chk("tc3_busy", busy_o, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk("tc3_hold_q", q_o, 0);
    chk("tc3_hold_tc", tc_o, 0);
    chk("tc3_hold_done", done_o, 1);
    step(0, 16'h0000, 1, 0, 1);
    chk("tc3_start_ign_busy", busy_o, 0);
    chk("tc3_start_ign_done", done_o, 1);
    step(1, 16'h0005, 0, 0, 0);
    chk("tc3_reload_q", q_o, 16'h0005);
    chk("tc3_reload_done", done_o, 0);
    chk("tc3_reload_busy", busy_o, 0);
`endif

    // ---------------- 3-tick period: reload or stop ----------------
    if (RELOAD) begin
      exp_q6  = '{16'h2, 16'h1, 16'h3, 16'h2, 16'h1, 16'h3, 16'h2};
    end else begin
      exp_q6  = '{16'h2, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    end
    exp_tc6 = '{0, 0, 1, 0, 0, RELOAD, 0};
    step(1, 16'h0003, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 16'h0000, 0, 0, 1);
      chk($sformatf("per%0d_q", k), q_o, exp_q6[k]);
      chk($sformatf("per%0d_tc", k), tc_o, exp_tc6[k]);
      chk($sformatf("per%0d_done", k), done_o, (!RELOAD && k >= 2) ? 1 : 0);
      chk($sformatf("per%0d_busy", k), busy_o, (RELOAD || k < 2) ? 1 : 0);
    end

    // ---------------- randomized run against the model ----------------
    do_reset();
    m_st = M_IDLE; m_val = 0; m_sh = 0; m_tc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      l  = ($urandom % 12) == 0;
      s  = ($urandom % 6) == 0;
      pa = ($urandom % 14) == 0;
      e  = ($urandom % 10) < 7;
      case ($urandom % 4)
        0:       pre = 16'($urandom);
        1:       pre = {8'h00, 8'($urandom)};
        default: pre = {12'h000, 4'($urandom_range(0, 11))};
      endcase
      step(l, pre, s, pa, e);
      model_step(l, pre, s, pa, e);
      chk($sformatf("rnd%0d_q", c), q_o, int_to_bcd(m_val));
      chk($sformatf("rnd%0d_tc", c), tc_o, m_tc);
      chk($sformatf("rnd%0d_busy", c), busy_o, m_st == M_RUN);
      chk($sformatf("rnd%0d_done", c), done_o, m_st == M_DONE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
